// File: rtl/cip_mubi_cov_monitor.sv
// Coverage monitor for multi-bit boolean channels: per-channel true/false/invalid
// and toggle counters, sticky invalid flags, first-invalid capture, and coverage
// (both values seen and both toggle directions seen).
module cip_mubi_cov_monitor #(
    parameter  int unsigned NumMubis = 1,
    parameter  int unsigned Width    = 4,
    parameter  int unsigned CntW     = 16,
    localparam int unsigned IdxW     = (NumMubis > 1) ? $clog2(NumMubis) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic                       clr_i,
    input  logic [NumMubis*Width-1:0]  mubis_i,
    output logic [NumMubis*CntW-1:0]   true_cnt_o,
    output logic [NumMubis*CntW-1:0]   false_cnt_o,
    output logic [NumMubis*CntW-1:0]   inval_cnt_o,
    output logic [NumMubis*CntW-1:0]   toggle_cnt_o,
    output logic [NumMubis-1:0]        invalid_o,
    output logic                       first_inval_vld_o,
    output logic [IdxW-1:0]            first_inval_idx_o,
    output logic [NumMubis-1:0]        covered_o,
    output logic                       all_covered_o
);

    localparam logic [15:0]      TruePat  = 16'h9696;
    localparam logic [Width-1:0] TrueVal  = TruePat[Width-1:0];
    localparam logic [Width-1:0] FalseVal = ~TrueVal;

    function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
        return (v == {CntW{1'b1}}) ? v : v + CntW'(1);
    endfunction

    logic [NumMubis*CntW-1:0] true_q,   true_d;
    logic [NumMubis*CntW-1:0] false_q,  false_d;
    logic [NumMubis*CntW-1:0] inval_q,  inval_d;
    logic [NumMubis*CntW-1:0] toggle_q, toggle_d;
    logic [NumMubis-1:0]      invalid_q,  invalid_d;
    logic [NumMubis-1:0]      prev_vld_q, prev_vld_d;
    logic [NumMubis-1:0]      prev_cls_q, prev_cls_d;
    logic [NumMubis-1:0]      seen_t_q,   seen_t_d;
    logic [NumMubis-1:0]      seen_f_q,   seen_f_d;
    logic [NumMubis-1:0]      seen_tf_q,  seen_tf_d;
    logic [NumMubis-1:0]      seen_ft_q,  seen_ft_d;
    logic [NumMubis-1:0]      covered_q,  covered_d;
    logic                     all_cov_q,  all_cov_d;
    logic                     first_vld_q, first_vld_d;
    logic [IdxW-1:0]          first_idx_q, first_idx_d;

    logic [NumMubis-1:0]      is_t_c, is_f_c, is_i_c;
    logic                     any_inval_c;
    logic [IdxW-1:0]          low_inval_c;

    // Classify each channel's current value
    always_comb begin
        is_t_c = '0;
        is_f_c = '0;
        for (int k = 0; k < NumMubis; k++) begin
            is_t_c[k] = (mubis_i[k*Width +: Width] == TrueVal);
            is_f_c[k] = (mubis_i[k*Width +: Width] == FalseVal);
        end
        is_i_c = ~(is_t_c | is_f_c);
    end

    // Lowest-indexed invalid channel this cycle
    always_comb begin
        any_inval_c = |is_i_c;
        low_inval_c = '0;
        for (int k = NumMubis - 1; k >= 0; k--) begin
            if (is_i_c[k]) low_inval_c = IdxW'(k);
        end
    end

    // Next-state statistics for an enabled sample
    always_comb begin
        true_d      = true_q;
        false_d     = false_q;
        inval_d     = inval_q;
        toggle_d    = toggle_q;
        invalid_d   = invalid_q;
        prev_vld_d  = prev_vld_q;
        prev_cls_d  = prev_cls_q;
        seen_t_d    = seen_t_q;
        seen_f_d    = seen_f_q;
        seen_tf_d   = seen_tf_q;
        seen_ft_d   = seen_ft_q;
        first_vld_d = first_vld_q;
        first_idx_d = first_idx_q;
        if (en_i) begin
            for (int k = 0; k < NumMubis; k++) begin
                if (is_t_c[k]) begin
                    true_d[k*CntW +: CntW] = sat_inc(true_q[k*CntW +: CntW]);
                    seen_t_d[k] = 1'b1;
                end
                if (is_f_c[k]) begin
                    false_d[k*CntW +: CntW] = sat_inc(false_q[k*CntW +: CntW]);
                    seen_f_d[k] = 1'b1;
                end
                if (is_i_c[k]) begin
                    inval_d[k*CntW +: CntW] = sat_inc(inval_q[k*CntW +: CntW]);
                    invalid_d[k] = 1'b1;
                end
                // Invalid samples are transparent to toggle pairing
                if (!is_i_c[k]) begin
                    if (prev_vld_q[k] && (prev_cls_q[k] != is_t_c[k])) begin
                        toggle_d[k*CntW +: CntW] = sat_inc(toggle_q[k*CntW +: CntW]);
                        if (prev_cls_q[k]) seen_tf_d[k] = 1'b1;
                        else               seen_ft_d[k] = 1'b1;
                    end
                    prev_vld_d[k] = 1'b1;
                    prev_cls_d[k] = is_t_c[k];
                end
            end
            if (!first_vld_q && any_inval_c) begin
                first_vld_d = 1'b1;
                first_idx_d = low_inval_c;
            end
        end
        covered_d = seen_t_d & seen_f_d & seen_tf_d & seen_ft_d;
        all_cov_d = &covered_d;
    end

    // State register; reset and clear both return everything to zero
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            true_q      <= '0;
            false_q     <= '0;
            inval_q     <= '0;
            toggle_q    <= '0;
            invalid_q   <= '0;
            prev_vld_q  <= '0;
            prev_cls_q  <= '0;
            seen_t_q    <= '0;
            seen_f_q    <= '0;
            seen_tf_q   <= '0;
            seen_ft_q   <= '0;
            covered_q   <= '0;
            all_cov_q   <= 1'b0;
            first_vld_q <= 1'b0;
            first_idx_q <= '0;
        end else begin
            true_q      <= true_d;
            false_q     <= false_d;
            inval_q     <= inval_d;
            toggle_q    <= toggle_d;
            invalid_q   <= invalid_d;
            prev_vld_q  <= prev_vld_d;
            prev_cls_q  <= prev_cls_d;
            seen_t_q    <= seen_t_d;
            seen_f_q    <= seen_f_d;
            seen_tf_q   <= seen_tf_d;
            seen_ft_q   <= seen_ft_d;
            covered_q   <= covered_d;
            all_cov_q   <= all_cov_d;
            first_vld_q <= first_vld_d;
            first_idx_q <= first_idx_d;
        end
    end

    assign true_cnt_o        = true_q;
    assign false_cnt_o       = false_q;
    assign inval_cnt_o       = inval_q;
    assign toggle_cnt_o      = toggle_q;
    assign invalid_o         = invalid_q;
    assign first_inval_vld_o = first_vld_q;
    assign first_inval_idx_o = first_idx_q;
    assign covered_o         = covered_q;
    assign all_covered_o     = all_cov_q;

endmodule

// File: tb/tb_cip_mubi_cov_monitor.sv
// Directed bench: a 4-channel 4-bit monitor with 2-bit counters and a
// single-channel 8-bit monitor with 16-bit counters, sharing one clock.
module tb_cip_mubi_cov_monitor;

    logic        clk = 1'b0;
    logic        rst, en, clr;
    logic [15:0] mubis;
    logic [7:0]  tc, fc, ic, gc;
    logic [3:0]  inv, cov;
    logic        fiv, allc;
    logic [1:0]  fii;

    logic        en8, clr8;
    logic [7:0]  mubis8;
    logic [15:0] tc8, fc8, ic8, gc8;
    logic        inv8, fiv8, cov8, allc8;
    logic        fii8;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    cip_mubi_cov_monitor #(.NumMubis(4), .Width(4), .CntW(2)) u_dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .mubis_i(mubis),
        .true_cnt_o(tc), .false_cnt_o(fc), .inval_cnt_o(ic), .toggle_cnt_o(gc),
        .invalid_o(inv), .first_inval_vld_o(fiv), .first_inval_idx_o(fii),
        .covered_o(cov), .all_covered_o(allc)
    );

    cip_mubi_cov_monitor #(.NumMubis(1), .Width(8), .CntW(16)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .en_i(en8), .clr_i(clr8), .mubis_i(mubis8),
        .true_cnt_o(tc8), .false_cnt_o(fc8), .inval_cnt_o(ic8), .toggle_cnt_o(gc8),
        .invalid_o(inv8), .first_inval_vld_o(fiv8), .first_inval_idx_o(fii8),
        .covered_o(cov8), .all_covered_o(allc8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; clr = 1'b0; en8 = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; clr = 1'b0; mubis = 16'h0000;
        en8 = 1'b1; clr8 = 1'b0; mubis8 = 8'h00;
        tick();
        rst = 1'b0; en = 1'b0; en8 = 1'b0;
        total++; if ({tc, fc, ic, gc} !== 32'h0) $display("FAIL reset_cnt got=%h exp=0", {tc, fc, ic, gc}); else passed++;
        total++; if ({inv, cov, allc, fiv, fii} !== 12'h0) $display("FAIL reset_flags got=%h exp=0", {inv, cov, allc, fiv, fii}); else passed++;
        total++; if ({tc8, fc8, ic8, gc8, inv8, fiv8, fii8, cov8, allc8} !== 69'h0) $display("FAIL reset_dut8 got=%h exp=0", {tc8, fc8, ic8, gc8}); else passed++;
    endtask

    task automatic test_cov8();
        logic [7:0] seq [4];
        seq = '{8'h96, 8'h69, 8'h96, 8'h69};
        en8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mubis8 = seq[i];
            tick();
        end
        en8 = 1'b0;
        total++; if (tc8 !== 16'd2) $display("FAIL cov8_true got=%0d exp=2", tc8); else passed++;
        total++; if (fc8 !== 16'd2) $display("FAIL cov8_false got=%0d exp=2", fc8); else passed++;
        total++; if (gc8 !== 16'd3) $display("FAIL cov8_toggle got=%0d exp=3", gc8); else passed++;
        total++; if (ic8 !== 16'd0) $display("FAIL cov8_inval got=%0d exp=0", ic8); else passed++;
        total++; if ({cov8, allc8} !== 2'b11) $display("FAIL cov8_covered got=%b exp=11", {cov8, allc8}); else passed++;
    endtask

    task automatic test_first_inval();
        do_reset();
        en = 1'b1; mubis = 16'hF609;
        tick();
        total++; if (inv !== 4'b1010) $display("FAIL finv_invalid got=%b exp=1010", inv); else passed++;
        total++; if ({fiv, fii} !== 3'b101) $display("FAIL finv_first got=%b exp=101", {fiv, fii}); else passed++;
        total++; if (ic !== 8'h44) $display("FAIL finv_icnt got=%h exp=44", ic); else passed++;
        total++; if ({tc, fc} !== 16'h1001) $display("FAIL finv_tf got=%h exp=1001", {tc, fc}); else passed++;
        mubis = 16'h6660;
        tick();
        en = 1'b0;
        total++; if (inv !== 4'b1011) $display("FAIL finv_invalid2 got=%b exp=1011", inv); else passed++;
        total++; if ({fiv, fii} !== 3'b101) $display("FAIL finv_sticky got=%b exp=101", {fiv, fii}); else passed++;
        total++; if ({tc, ic, gc} !== 24'h644500) $display("FAIL finv_cnt2 got=%h exp=644500", {tc, ic, gc}); else passed++;
    endtask

    task automatic test_saturate();
        do_reset();
        en = 1'b1; mubis = 16'h6666;
        for (int i = 0; i < 5; i++) tick();
        total++; if (tc !== 8'hFF) $display("FAIL sat_true got=%h exp=ff", tc); else passed++;
        total++; if ({fc, gc, cov} !== 20'h0) $display("FAIL sat_other got=%h exp=0", {fc, gc, cov}); else passed++;
        mubis = 16'h9999;
        tick();
        total++; if ({tc, fc, gc} !== 24'hFF5555) $display("FAIL sat_f got=%h exp=ff5555", {tc, fc, gc}); else passed++;
        mubis = 16'h6666;
        tick();
        en = 1'b0;
        total++; if ({tc, gc} !== 16'hFFAA) $display("FAIL sat_t2 got=%h exp=ffaa", {tc, gc}); else passed++;
        total++; if ({cov, allc} !== 5'b11111) $display("FAIL sat_cov got=%b exp=11111", {cov, allc}); else passed++;
    endtask

    task automatic test_seq_enable();
        logic [15:0] seq [3];
        seq = '{16'h6666, 16'h5555, 16'h9999};
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mubis = seq[i];
            tick();
        end
        en = 1'b0; mubis = 16'h6666;
        tick();
        total++; if ({tc, fc, ic, gc} !== 32'h55555555) $display("FAIL seq_cnt got=%h exp=55555555", {tc, fc, ic, gc}); else passed++;
        total++; if ({inv, fiv, fii, cov} !== 11'b1111_1_00_0000) $display("FAIL seq_flags got=%b exp=11111000000", {inv, fiv, fii, cov}); else passed++;
    endtask

    task automatic test_clear();
        clr = 1'b1; en = 1'b1; mubis = 16'h6666;
        tick();
        clr = 1'b0; en = 1'b0;
        total++; if ({tc, fc, ic, gc} !== 32'h0) $display("FAIL clr_cnt got=%h exp=0", {tc, fc, ic, gc}); else passed++;
        total++; if ({inv, cov, allc, fiv, fii} !== 12'h0) $display("FAIL clr_flags got=%h exp=0", {inv, cov, allc, fiv, fii}); else passed++;
        en = 1'b1; mubis = 16'h0666;
        tick();
        en = 1'b0;
        total++; if ({inv, fiv, fii} !== 7'b1000_1_11) $display("FAIL clr_refirst got=%b exp=1000111", {inv, fiv, fii}); else passed++;
        total++; if ({tc, gc} !== 16'h1500) $display("FAIL clr_recnt got=%h exp=1500", {tc, gc}); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 1'b1; mubis = 16'h6666;
        tick();
        total++; if (tc !== 8'h55) $display("FAIL rmid_pre got=%h exp=55", tc); else passed++;
        rst = 1'b1; mubis = 16'h9999;
        tick();
        rst = 1'b0;
        total++; if ({tc, fc, gc} !== 24'h0) $display("FAIL rmid_rst got=%h exp=0", {tc, fc, gc}); else passed++;
        tick();
        total++; if ({fc, gc} !== 16'h5500) $display("FAIL rmid_notoggle got=%h exp=5500", {fc, gc}); else passed++;
        mubis = 16'h6666;
        tick();
        en = 1'b0;
        total++; if (gc !== 8'h55) $display("FAIL rmid_toggle got=%h exp=55", gc); else passed++;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; mubis = '0;
        en8 = 1'b0; clr8 = 1'b0; mubis8 = '0;
        tick();
        test_reset();
        test_cov8();
        test_first_inval();
        test_saturate();
        test_seq_enable();
        test_clear();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cip_mubi_cov_monitor.md
CIP_MUBI_COV_MONITOR -- requirements
Module: cip_mubi_cov_monitor

Interface
REQ-001 Parameter NumMubis, default 1: number of monitored multi-bit boolean channels, range 1..32.
REQ-002 Parameter Width, default 4: bits per channel, even, range 4..16.
REQ-003 Parameter CntW, default 16: width of each per-channel event counter, range 2..32.
REQ-004 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 en_i  input  1  sample strobe; channels are sampled only in cycles with en_i=1.
REQ-007 clr_i  input  1  synchronous clear of all statistics.
REQ-008 mubis_i  input  NumMubis*Width  channel k occupies bits [k*Width +: Width].
REQ-009 true_cnt_o, false_cnt_o, inval_cnt_o, toggle_cnt_o  output  NumMubis*CntW each  per-channel counters, channel k at [k*CntW +: CntW].
REQ-010 invalid_o  output  NumMubis  sticky per-channel "invalid value seen" flag.
REQ-011 first_inval_vld_o  output  1; first_inval_idx_o  output  $clog2(NumMubis) (min 1)  index of first channel to go invalid.
REQ-012 covered_o  output  NumMubis  per-channel coverage complete; all_covered_o  output  1  AND of covered_o.

Function
REQ-013 True encoding SHALL be the low Width bits of repeated hex 0x...9696 (4'h6, 8'h96, 12'h696, 16'h9696); False SHALL be its bitwise inverse; every other value is Invalid.
REQ-014 In each cycle with en_i=1 and clr_i=0, each channel SHALL be classified and exactly one of its true/false/inval counters incremented; results visible on outputs the next cycle (latency 1).
REQ-015 Counters SHALL saturate at all-ones and hold; no wrap-around.
REQ-016 Per channel, prev_vld/prev_class SHALL record the last True/False sample; Invalid samples leave them unchanged.
REQ-017 toggle_cnt SHALL increment when a True/False sample differs from prev_class with prev_vld=1; an intervening Invalid does not break the pairing (T,Inv,F = one toggle).
REQ-018 Per channel, flags seen_t, seen_f, seen_tf (True->False toggle) and seen_ft (False->True toggle) SHALL be sticky; covered_o[k] = seen_t & seen_f & seen_tf & seen_ft.
REQ-019 Sticky flags (seen_*, invalid_o) SHALL NOT saturate or depend on counter saturation.
REQ-020 invalid_o[k] SHALL set the cycle after channel k is sampled Invalid and hold until clear/reset.
REQ-021 first_inval_vld_o SHALL set on the first Invalid sample after clear/reset; first_inval_idx_o captures the lowest-indexed Invalid channel of that cycle; later Invalids do not change it.
REQ-022 Cycles with en_i=0 SHALL leave all state unchanged regardless of mubis_i.
REQ-023 clr_i=1 SHALL return all state to reset values next cycle and take priority over en_i in the same cycle (that cycle's sample is discarded).

Reset
REQ-024 rst_i=1 at a rising edge SHALL set all counters, flags, prev_vld, first_inval_vld_o, first_inval_idx_o, covered_o and all_covered_o to 0; rst_i has priority over clr_i and en_i.
REQ-025 Reset asserted mid-operation SHALL discard that cycle's sample; first enabled sample after deassertion counts with prev_vld=0 (no toggle).

Verification
REQ-026 Width=8, NumMubis=1: samples 8'h96,8'h69,8'h96,8'h69 -> true_cnt=2, false_cnt=2, toggle_cnt=3, covered_o=1, all_covered_o=1.
REQ-027 Width=4, NumMubis=4: cycle with ch1=4'h0, ch3=4'hF, others valid -> next cycle invalid_o=4'b1010, first_inval_vld_o=1, first_inval_idx_o=1; later ch0 Invalid -> idx stays 1.
REQ-028 CntW=2: five True samples -> true_cnt=3 held; seen_t=1.
REQ-029 Sequence 4'h6, 4'h5, 4'h9 with en_i=1, then 4'h6 with en_i=0 -> toggle_cnt=1, inval_cnt=1, true_cnt=1, false_cnt=1.
REQ-030 clr_i and en_i both 1 with True sample, all counters nonzero -> next cycle all outputs 0; rst_i mid-stream -> all outputs 0, first following True/False sample yields toggle_cnt=0.
